// File: rtl/npu_kernel_loader.sv
// npu_kernel_loader: fetches kernel coefficients from weight memory into the kernel register file
module npu_kernel_loader #(
  parameter int DATA_W      = 8,
  parameter int KERNEL_SIZE = 9,
  parameter int NUM_KERNELS = 4,
  parameter int MEM_AW      = 10,
  parameter int REG_AW      = 6,
  parameter int KSEL_W      = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [KSEL_W-1:0] i_kernel_sel,
  input  logic [MEM_AW-1:0] i_base_addr,
  input  logic              i_abort,
  output logic              o_mem_rd_en,
  output logic [MEM_AW-1:0] o_mem_rd_addr,
  input  logic [DATA_W-1:0] i_mem_rd_data,
  input  logic              i_mem_rd_valid,
  output logic              o_kreg_wr_en,
  output logic [REG_AW-1:0] o_kreg_wr_addr,
  output logic [DATA_W-1:0] o_kreg_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [2:0]        o_state,
  output logic [KSEL_W-1:0] o_kernel_idx
);
  localparam int EW = KERNEL_SIZE > 1 ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  logic [2:0]        state;
  logic              mode;
  logic              err;
  logic [KSEL_W-1:0] k;
  logic [EW-1:0]     e;
  logic [MEM_AW-1:0] base;
  logic [DATA_W-1:0] data;
  logic              last_e;
  logic              bad_sel;
  assign last_e  = e == EW'(KERNEL_SIZE - 1);
  assign bad_sel = i_mode && (i_kernel_sel >= KSEL_W'(NUM_KERNELS));
  // Sequencer: one read request, wait for its data, one register-file write per coefficient
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      mode  <= 1'b0;
      err   <= 1'b0;
      k     <= '0;
      e     <= '0;
      base  <= '0;
      data  <= '0;
    end else if (i_abort) begin
      state <= IDLE;
      err   <= 1'b0;
      k     <= '0;
      e     <= '0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          mode  <= i_mode;
          base  <= i_base_addr;
          e     <= '0;
          k     <= i_mode && !bad_sel ? i_kernel_sel : '0;
          err   <= bad_sel;
          state <= bad_sel ? DONE : REQ;
        end
        REQ: state <= WAIT;
        WAIT: if (i_mem_rd_valid) begin
          data  <= i_mem_rd_data;
          state <= WRITE;
        end
        WRITE: begin
          e     <= last_e ? '0 : e + EW'(1);
          k     <= last_e ? k + KSEL_W'(1) : k;
          state <= last_e && (mode || k == KSEL_W'(NUM_KERNELS - 1)) ? DONE : REQ;
        end
        DONE: begin
          state <= IDLE;
          err   <= 1'b0;
          k     <= '0;
          e     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign o_mem_rd_en    = state == REQ;
  assign o_mem_rd_addr  = base + MEM_AW'(k) * MEM_AW'(KERNEL_SIZE) + MEM_AW'(e);
  assign o_kreg_wr_en   = state == WRITE && !i_abort && i_rst_n;
  assign o_kreg_wr_addr = REG_AW'(k) * REG_AW'(KERNEL_SIZE) + REG_AW'(e);
  assign o_kreg_wr_data = data;
  assign o_busy         = state != IDLE;
  assign o_done         = state == DONE;
  assign o_err          = state == DONE && err;
  assign o_state        = state;
  assign o_kernel_idx   = k;
endmodule

// File: tb/tb_npu_kernel_loader.sv
// tb_npu_kernel_loader: directed scoreboard bench for the kernel loader
module tb_npu_kernel_loader;
  localparam int KS = 9;
  localparam int NK = 4;
  typedef struct {int addr; int data;} wr_t;
  logic       i_clk, i_rst_n, i_start, i_mode, i_abort, i_mem_rd_valid;
  logic [2:0] i_kernel_sel;
  logic [9:0] i_base_addr;
  logic [7:0] i_mem_rd_data;
  logic       o_mem_rd_en, o_kreg_wr_en, o_busy, o_done, o_err;
  logic [9:0] o_mem_rd_addr;
  logic [5:0] o_kreg_wr_addr;
  logic [7:0] o_kreg_wr_data;
  logic [2:0] o_state, o_kernel_idx;
  int total = 0, bad = 0;
  int cyc = 0, t0 = 0, lat = 1, gap = 3, last_wr = -1;
  int nwr = 0, nrd = 0, ndone = 0, nerr = 0, done_rel = -1;
  wr_t sb[$];
  int rdq[$];
  wr_t w;
  logic [9:0] ra;

  npu_kernel_loader dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_mode(i_mode),
    .i_kernel_sel(i_kernel_sel), .i_base_addr(i_base_addr), .i_abort(i_abort),
    .o_mem_rd_en(o_mem_rd_en), .o_mem_rd_addr(o_mem_rd_addr),
    .i_mem_rd_data(i_mem_rd_data), .i_mem_rd_valid(i_mem_rd_valid),
    .o_kreg_wr_en(o_kreg_wr_en), .o_kreg_wr_addr(o_kreg_wr_addr),
    .o_kreg_wr_data(o_kreg_wr_data), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_state(o_state), .o_kernel_idx(o_kernel_idx)
  );

  initial begin
    i_clk = 0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // weight memory: mem[a] = a[7:0], answering L cycles after each request
  initial begin
    i_mem_rd_valid = 0;
    i_mem_rd_data  = 0;
    forever begin
      @(posedge i_clk);
      #1;
      if (o_mem_rd_en === 1'b1) begin
        ra = o_mem_rd_addr;
        repeat (lat) @(posedge i_clk);
        #1 i_mem_rd_valid = 1;
        i_mem_rd_data = ra[7:0];
        @(posedge i_clk);
        #1 i_mem_rd_valid = 0;
      end
    end
  end

  // output monitor on the falling edge: pops the scoreboard on every write
  initial forever begin
    @(negedge i_clk);
    if (o_mem_rd_en === 1'b1) begin
      nrd++;
      chk("rdq_has_entry", rdq.size() > 0, 1);
      if (rdq.size() > 0) chk("rd_addr", o_mem_rd_addr, rdq.pop_front());
    end
    if (o_kreg_wr_en === 1'b1) begin
      chk("sb_has_entry", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        w = sb.pop_front();
        chk("wr_addr", o_kreg_wr_addr, w.addr);
        chk("wr_data", o_kreg_wr_data, w.data);
      end
      if (last_wr < 0) chk("first_wr_cycle", cyc - t0, gap);
      else chk("wr_gap", cyc - t0 - last_wr, gap);
      last_wr = cyc - t0;
      nwr++;
    end
    if (o_done === 1'b1) begin
      ndone++;
      done_rel = cyc - t0;
    end
    if (o_err === 1'b1) nerr++;
  end

  task automatic start_load(input logic m, input int s, input int b, input int l);
    lat = l; gap = l + 2; last_wr = -1;
    nwr = 0; nrd = 0; ndone = 0; nerr = 0; done_rel = -1;
    if (!(m && s >= NK))
      for (int kk = (m ? s : 0); kk < (m ? s + 1 : NK); kk++)
        for (int ee = 0; ee < KS; ee++) begin
          sb.push_back('{kk * KS + ee, (b + kk * KS + ee) & 255});
          rdq.push_back((b + kk * KS + ee) & 1023);
        end
    i_mode = m; i_kernel_sel = 3'(s); i_base_addr = 10'(b); i_start = 1;
    @(posedge i_clk);
    #1 i_start = 0;
    t0 = cyc - 1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (ndone == 0 && n < budget) begin
      @(posedge i_clk);
      #1 n++;
    end
    chk("done_seen", ndone != 0, 1);
  endtask

  task automatic end_checks(input int words, input int l);
    chk("done_cycle", done_rel, words * (l + 2) + 1);
    chk("done_count", ndone, 1);
    chk("write_count", nwr, words);
    chk("read_count", nrd, words);
    chk("sb_drained", sb.size(), 0);
    chk("no_err", nerr, 0);
    chk("busy_fall", o_busy, 0);
    chk("busy_fall_cycle", cyc - t0, words * (l + 2) + 2);
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL global_timeout observed=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    i_rst_n = 0; i_start = 0; i_mode = 0; i_abort = 0;
    i_kernel_sel = 0; i_base_addr = 0;
    repeat (3) begin
      {i_start, i_mode, i_abort} = 3'($urandom);
      i_kernel_sel = 3'($urandom);
      i_base_addr = 10'($urandom);
      @(posedge i_clk);
      #1 chk("rst_state", o_state, 0);
      chk("rst_outputs", {o_mem_rd_en, o_mem_rd_addr, o_kreg_wr_en, o_kreg_wr_addr,
                          o_kreg_wr_data, o_busy, o_done, o_err, o_kernel_idx}, 0);
    end
    i_start = 0; i_mode = 0; i_abort = 0; i_kernel_sel = 0; i_base_addr = 0;
    i_rst_n = 1;
    repeat (2) @(posedge i_clk);
    #1 chk("post_rst_idle", o_state, 0);

    start_load(0, 0, 0, 1);
    chk("busy_cycle1", o_busy, 1);
    chk("req_cycle1", o_state, 1);
    wait_done(400);
    end_checks(36, 1);

    start_load(1, 2, 'h3F0, 3);
    chk("m1_kidx", o_kernel_idx, 2);
    wait_done(200);
    end_checks(9, 3);

    start_load(1, 5, 0, 1);
    chk("err_pulse", o_err, 1);
    chk("err_done", o_done, 1);
    chk("err_state", o_state, 4);
    @(posedge i_clk);
    #1 chk("err_back_idle", o_state, 0);
    chk("err_no_reads", nrd, 0);
    chk("err_no_writes", nwr, 0);
    chk("err_count", nerr, 1);
    chk("err_done_cycle", done_rel, 1);

    start_load(0, 0, 'h020, 3);
    n = 0;
    while (nwr < 10 && n < 500) begin @(posedge i_clk); #1 n++; end
    while (o_state !== 3'd2 && n < 500) begin @(posedge i_clk); #1 n++; end
    chk("abort_reach_wait", o_state, 2);
    i_abort = 1;
    @(posedge i_clk);
    #1 i_abort = 0;
    chk("abort_idle", o_state, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_kidx", o_kernel_idx, 0);
    sb.delete();
    rdq.delete();
    repeat (6) @(posedge i_clk);
    #1 chk("abort_writes", nwr, 10);
    chk("abort_no_done", ndone, 0);
    chk("abort_stay_idle", o_state, 0);
    start_load(0, 0, 'h020, 1);
    wait_done(400);
    end_checks(36, 1);

    start_load(0, 0, 'h100, 2);
    repeat (20) @(posedge i_clk);
    #1 i_mode = 1; i_kernel_sel = 3; i_start = 1;
    @(posedge i_clk);
    #1 i_start = 0;
    n = 0;
    while (o_state !== 3'd4 && n < 400) begin @(posedge i_clk); #1 n++; end
    chk("glitch_reach_done", o_state, 4);
    i_start = 1;
    @(posedge i_clk);
    #1 i_start = 0;
    chk("start_in_done_ignored", o_state, 0);
    end_checks(36, 2);

    start_load(1, 1, 0, 1);
    n = 0;
    while (o_state !== 3'd3 && n < 20) begin @(posedge i_clk); #1 n++; end
    chk("rst_reach_write", o_state, 3);
    i_rst_n = 0;
    #1 chk("rst_wr_suppressed", o_kreg_wr_en, 0);
    @(posedge i_clk);
    #1 i_rst_n = 1;
    chk("rst_mid_idle", o_state, 0);
    chk("rst_mid_busy", o_busy, 0);
    sb.delete();
    rdq.delete();
    repeat (3) @(posedge i_clk);
    #1 chk("rst_mid_writes", nwr, 0);
    chk("rst_mid_no_done", ndone, 0);
    chk("rst_mid_stay_idle", o_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
